// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/execute control FSM for the accumulator datapath.
// Optional memory-ready handshake is enabled with `define FETCH_CTRL_MEMREADY_EN.
module fetch_decode_ctrl #(
  parameter int W    = 16,
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RSTn,
`ifdef FETCH_CTRL_MEMREADY_EN
  input  logic            memReady,
`endif
  input  logic [W-1:0]    IMOut,
  input  logic            accZero,
  output logic [W-1:0]    IR,
  output logic            PCWrite,
  output logic [1:0]      PCSelect,
  output logic            IMWrite,
  output logic [1:0]      ALUOp,
  output logic            ALUSrcEn,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            AccWrite,
  output logic            AccSrc,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] instrCount
);

  typedef enum logic [2:0] {F0, F1, DEC, EXE, MEM, WB, HLT} state_e;

  localparam logic [OPW-1:0] OP_LOAD  = OPW'(4);
  localparam logic [OPW-1:0] OP_STORE = OPW'(5);
  localparam logic [OPW-1:0] OP_BZ    = OPW'(6);
  localparam logic [OPW-1:0] OP_JR    = OPW'(7);
  localparam logic [OPW-1:0] OP_J     = OPW'(8);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(15);

  state_e         state;
  logic           pcWriteR;
  logic [1:0]     pcSelR;
  logic           bzR;
  logic           memReadR;
  logic           memWriteR;
  logic           aluSrcEnR;
  logic [1:0]     aluOpR;
  logic           accWriteR;
  logic           accSrcR;
  logic           memReadyInt;
  logic           storeWait;
  logic           memWait;
  logic [OPW-1:0] imOp;
  logic [OPW-1:0] irOp;

`ifdef FETCH_CTRL_MEMREADY_EN
  assign memReadyInt = memReady;
`else
  assign memReadyInt = 1'b1;
`endif

  assign imOp = IMOut[W-1:W-OPW];
  assign irOp = IR[W-1:W-OPW];

  // Stall qualifiers only ever fire when the handshake is compiled in.
  assign storeWait = (state == DEC) && (irOp == OP_STORE) && !memReadyInt;
  assign memWait   = (state == MEM) && !memReadyInt;

  assign PCWrite  = pcWriteR && !storeWait;
  assign PCSelect = {pcSelR[1], pcSelR[0] | (bzR & accZero)};
  assign MemRead  = memReadR | memWait;
  assign MemWrite = memWriteR;
  assign ALUSrcEn = aluSrcEnR;
  assign ALUOp    = aluOpR;
  assign AccWrite = accWriteR;
  assign AccSrc   = accSrcR;
  assign IMWrite  = 1'b0;

  // Strobes are registered for the state being entered, so decode looks at IMOut on the F1 edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= F0;
      IR         <= '0;
      instrCount <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      pcWriteR   <= 1'b0;
      pcSelR     <= 2'b00;
      bzR        <= 1'b0;
      memReadR   <= 1'b0;
      memWriteR  <= 1'b0;
      aluSrcEnR  <= 1'b0;
      aluOpR     <= 2'b00;
      accWriteR  <= 1'b0;
      accSrcR    <= 1'b0;
    end else begin
      pcWriteR  <= 1'b0;
      pcSelR    <= 2'b00;
      bzR       <= 1'b0;
      memReadR  <= 1'b0;
      memWriteR <= 1'b0;
      aluSrcEnR <= 1'b0;
      aluOpR    <= 2'b00;
      accWriteR <= 1'b0;
      accSrcR   <= 1'b0;
      if (PCWrite)
        instrCount <= instrCount + CNTW'(1);
      case (state)
        F0: state <= F1;
        F1: begin
          IR    <= IMOut;
          state <= DEC;
          if (imOp <= OP_LOAD) begin
            memReadR <= 1'b1;
          end else if (imOp == OP_STORE) begin
            memWriteR <= 1'b1;
            pcWriteR  <= 1'b1;
          end else if (imOp == OP_BZ) begin
            pcWriteR <= 1'b1;
            bzR      <= 1'b1;
          end else if (imOp == OP_JR) begin
            pcWriteR <= 1'b1;
            pcSelR   <= 2'b10;
          end else if (imOp == OP_J) begin
            pcWriteR <= 1'b1;
            pcSelR   <= 2'b11;
          end else if (imOp != OP_HALT) begin
            pcWriteR <= 1'b1;
          end
        end
        DEC: begin
          if (irOp <= OP_LOAD) begin
            state <= MEM;
          end else if (irOp == OP_HALT) begin
            state  <= HLT;
            halted <= 1'b1;
          end else if (storeWait) begin
            memWriteR <= 1'b1;
            pcWriteR  <= 1'b1;
          end else begin
            state <= F0;
            if (irOp > OP_J)
              illegal <= 1'b1;
          end
        end
        MEM: begin
          if (memReadyInt) begin
            if (irOp == OP_LOAD) begin
              state     <= WB;
              accWriteR <= 1'b1;
              accSrcR   <= 1'b1;
              pcWriteR  <= 1'b1;
            end else begin
              state     <= EXE;
              aluSrcEnR <= 1'b1;
              aluOpR    <= IR[W-OPW+1:W-OPW];
            end
          end
        end
        EXE: begin
          state     <= WB;
          accWriteR <= 1'b1;
          pcWriteR  <= 1'b1;
        end
        WB:      state <= F0;
        HLT:     state <= HLT;
        default: state <= F0;
      endcase
    end
  end

endmodule
